// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target that decodes START/STOP, matches a 7-bit address, then receives or returns bytes.
// Define I2C_GLITCH_FILTER_EN to require 3 equal samples before scl/sda are allowed to change.
module i2c_slave_fsm #(
  parameter logic [6:0]  SLAVE_ADDRESS = 7'b1011010,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_select,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_MACK,
    WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_raw, sda_raw;
  logic                   scl_s, sda_s;
  logic                   scl_p_q, sda_p_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_raw    = scl_sync_q[SYNC_STAGES-1];
    sda_raw    = sda_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, scl_h_d;
  logic [1:0] sda_h_q, sda_h_d;
  logic       scl_f_q, sda_f_q;

  // Output follows the input only once the current and two prior samples agree.
  always_comb begin
    scl_h_d = {scl_h_q[0], scl_raw};
    sda_h_d = {sda_h_q[0], sda_raw};
    scl_s   = (scl_h_q == {2{scl_raw}}) ? scl_raw : scl_f_q;
    sda_s   = (sda_h_q == {2{sda_raw}}) ? sda_raw : sda_f_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      scl_h_q <= 2'b11;
      sda_h_q <= 2'b11;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= scl_h_d;
      sda_h_q <= sda_h_d;
      scl_f_q <= scl_s;
      sda_f_q <= sda_s;
    end
  end
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_sh_q, tx_sh_d;
  logic       rw_q, rw_d;
  logic       ph_q, ph_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ack_q, tx_ack_d;
  logic       busy_q, busy_d;
  logic       sda_out_q, sda_out_d;
  logic       sda_sel_q, sda_sel_d;

  logic [7:0] byte_in;
  logic       last_bit;
  logic       addr_hit;

  assign byte_in  = {shift_q, sda_s};
  assign last_bit = (bit_cnt_q == 3'd7);
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDRESS) &&
                    (byte_in[7:1] != 7'd0);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      tx_sh_q    <= 7'd0;
      rw_q       <= 1'b0;
      ph_q       <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_out_q  <= 1'b1;
      sda_sel_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_sh_q    <= tx_sh_d;
      rw_q       <= rw_d;
      ph_q       <= ph_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ack_q   <= tx_ack_d;
      busy_q     <= busy_d;
      sda_out_q  <= sda_out_d;
      sda_sel_q  <= sda_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = IDLE;
    end else if (start_ev) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: state_d = state_q;
        ADDR:
          if (scl_rise && last_bit)
            state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          if (scl_fall && ph_q)
            state_d = rw_q ? TX_BYTE : RX_BYTE;
        RX_BYTE:
          if (scl_rise && last_bit) state_d = RX_ACK;
        RX_ACK:
          if (scl_fall && ph_q) state_d = RX_BYTE;
        TX_BYTE:
          if (scl_fall && last_bit) state_d = TX_MACK;
        TX_MACK:
          if (scl_rise && sda_s) state_d = WAIT_STOP;
          else if (scl_fall && ph_q) state_d = TX_BYTE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ph_q marks the second half of a two-step phase (ACK driven / master ACK seen).
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_sh_d    = tx_sh_q;
    rw_d       = rw_q;
    ph_d       = ph_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ack_d   = 1'b0;
    busy_d     = busy_q;
    sda_out_d  = sda_out_q;
    sda_sel_d  = sda_sel_q;
    if (stop_ev || start_ev) begin
      bit_cnt_d = 3'd0;
      ph_d      = 1'b0;
      busy_d    = 1'b0;
      sda_out_d = 1'b1;
      sda_sel_d = 1'b1;
    end else begin
      unique case (state_q)
        ADDR:
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rw_d   = byte_in[0];
              busy_d = addr_hit;
              ph_d   = 1'b0;
            end
          end
        ADDR_ACK, RX_ACK:
          if (scl_fall) begin
            if (!ph_q) begin
              ph_d      = 1'b1;
              sda_out_d = 1'b0;
              sda_sel_d = 1'b0;
            end else begin
              ph_d      = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                tx_sh_d   = tx_data[6:0];
                tx_ack_d  = 1'b1;
                sda_out_d = tx_data[7];
                sda_sel_d = 1'b0;
              end else begin
                sda_out_d = 1'b1;
                sda_sel_d = 1'b1;
              end
            end
          end
        RX_BYTE:
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              ph_d       = 1'b0;
            end
          end
        TX_BYTE:
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              ph_d      = 1'b0;
              sda_out_d = 1'b1;
              sda_sel_d = 1'b1;
            end else begin
              sda_out_d = tx_sh_q[6];
              tx_sh_d   = {tx_sh_q[5:0], 1'b0};
            end
          end
        TX_MACK:
          if (scl_rise && !sda_s) begin
            ph_d = 1'b1;
          end else if (scl_fall && ph_q) begin
            ph_d      = 1'b0;
            bit_cnt_d = 3'd0;
            tx_sh_d   = tx_data[6:0];
            tx_ack_d  = 1'b1;
            sda_out_d = tx_data[7];
            sda_sel_d = 1'b0;
          end
        default: ph_d = ph_q;
      endcase
    end
  end

  always_comb begin
    sda_out    = sda_out_q;
    sda_select = sda_sel_q;
    tx_ack     = tx_ack_q;
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: bus-level I2C master with a transaction model and
// a scoreboard monitor for rx bytes, ACK bits and read-back bytes.
`timescale 1ns/1ps
module tb_i2c_slave_fsm;
  localparam logic [6:0] SADDR = 7'b1011010;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       scl_in = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_in;
  logic       sda_out, sda_select, tx_ack, rx_valid, busy;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;

  assign sda_in = m_sda & (sda_select | sda_out);
  always #5 clk = ~clk;

  i2c_slave_fsm #(.SLAVE_ADDRESS(SADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_(rst_), .scl_in(scl_in), .sda_in(sda_in),
    .sda_out(sda_out), .sda_select(sda_select),
    .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hp = 10;
  int n_txack = 0;
  int exp_txack = 0;
  logic overlap = 1'b0;
  logic sel_low_seen = 1'b0;

  logic [7:0] exp_rx[$], exp_rd[$], obs_rd[$], pay[$];
  logic       exp_ack[$], obs_ack[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_valid_unexp", rx_valid, 0);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_ack) n_txack++;
      if (rx_valid && tx_ack) overlap = 1'b1;
      if (!sda_select) sel_low_seen = 1'b1;
      if (obs_ack.size() > 0 && exp_ack.size() > 0)
        chk("ack_bit", obs_ack.pop_front(), exp_ack.pop_front());
      if (obs_rd.size() > 0 && exp_rd.size() > 0)
        chk("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    clks(hp / 2);
    m_sda = b;
    clks(hp - hp / 2);
    scl_in = 1'b1;
    clks(hp / 2);
    seen = sda_in;
    clks(hp - hp / 2);
    scl_in = 1'b0;
  endtask

  task automatic bus_bit_glitch(input logic b);
    clks(hp / 2);
    m_sda = b;
    clks(hp - hp / 2);
    scl_in = 1'b1;
    clks(3);
    scl_in = 1'b0;
    clks(1);
    scl_in = 1'b1;
    clks(hp - 4);
    scl_in = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_in == 1'b0) begin
      clks(hp / 2);
      m_sda = 1'b1;
      clks(hp - hp / 2);
      scl_in = 1'b1;
    end
    clks(hp);
    m_sda = 1'b0;
    clks(hp);
    scl_in = 1'b0;
  endtask

  task automatic bus_stop();
    clks(hp / 2);
    m_sda = 1'b0;
    clks(hp - hp / 2);
    scl_in = 1'b1;
    clks(hp);
    m_sda = 1'b1;
    clks(hp);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int k = 7; k >= 0; k--) bus_bit(b[k], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, input logic [7:0] nxt,
                           output logic [7:0] b);
    logic s;
    for (int k = 7; k >= 0; k--) begin
      bus_bit(1'b1, s);
      b[k] = s;
    end
    if (!mack) tx_data = nxt;
    bus_bit(mack, s);
  endtask

  // Transaction model: ACK only for our non-zero address; a write
  // delivers each byte and ACKs it; a read returns tx bytes in order.
  task automatic xfer(input logic [6:0] a, input logic rw);
    logic s;
    logic [7:0] got, nxt;
    bit hit;
    hit = (a == SADDR) && (a != 7'd0);
    exp_ack.push_back(hit ? 1'b0 : 1'b1);
    if (rw && pay.size() > 0) tx_data = pay[0];
    send_byte({a, rw}, s);
    obs_ack.push_back(s);
    if (!hit) return;
    for (int i = 0; i < pay.size(); i++) begin
      if (!rw) begin
        exp_rx.push_back(pay[i]);
        exp_ack.push_back(1'b0);
        send_byte(pay[i], s);
        obs_ack.push_back(s);
      end else begin
        exp_rd.push_back(pay[i]);
        exp_txack++;
        nxt = 8'h00;
        if (i + 1 < pay.size()) nxt = pay[i + 1];
        recv_byte((i + 1 == pay.size()), nxt, got);
        obs_rd.push_back(got);
      end
    end
  endtask

  initial begin
    logic s;
    int t0;
    rst_ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      scl_in = 1'($urandom_range(0, 1));
      m_sda  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_outs", {sda_select, sda_out, busy, rx_valid, tx_ack},
          5'b11000);
    end
    chk("rst_rx_data", rx_data, 8'h00);
    scl_in = 1'b1;
    m_sda  = 1'b1;
    clks(4);
    rst_ = 1'b1;
    clks(6);

    hp = 10;
    pay.delete();
    pay.push_back(8'h57);
    pay.push_back(8'hEA);
    bus_start();
    xfer(7'h5A, 1'b0);
    chk("busy_before_stop", busy, 1);
    bus_stop();
    chk("busy_after_stop", busy, 0);
    chk("rx_hold", rx_data, 8'hEA);

    pay.delete();
    pay.push_back(8'hA5);
    pay.push_back(8'h3C);
    t0 = n_txack;
    bus_start();
    xfer(7'h5A, 1'b1);
    chk("busy_wait_stop", busy, 1);
    bus_stop();
    chk("txack_count", n_txack - t0, 2);
    chk("busy_after_read", busy, 0);

    sel_low_seen = 1'b0;
    pay.delete();
    pay.push_back(8'h11);
    bus_start();
    xfer(7'h58, 1'b0);
    bus_stop();
    chk("nomatch_released", sel_low_seen, 0);
    sel_low_seen = 1'b0;
    bus_start();
    xfer(7'h00, 1'b0);
    bus_stop();
    chk("gencall_released", sel_low_seen, 0);
    pay.delete();
    pay.push_back(8'h33);
    bus_start();
    xfer(7'h5A, 1'b0);
    bus_stop();

    bus_start();
    pay.delete();
    xfer(7'h5A, 1'b0);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    bus_stop();
    chk("partial_stop_busy", busy, 0);

    bus_start();
    xfer(7'h5A, 1'b0);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    bus_start();
    chk("rstart_busy", busy, 0);
    pay.push_back(8'h96);
    xfer(7'h5A, 1'b1);
    bus_stop();

`ifdef I2C_GLITCH_FILTER_EN
    hp = 10;
    bus_start();
    pay.delete();
    xfer(7'h5A, 1'b0);
    exp_rx.push_back(8'h57);
    exp_ack.push_back(1'b0);
    for (int k = 7; k >= 0; k--) begin
      logic [7:0] gb;
      gb = 8'h57;
      if (k == 4) bus_bit_glitch(gb[k]);
      else bus_bit(gb[k], s);
    end
    bus_bit(1'b1, s);
    obs_ack.push_back(s);
    bus_stop();
`endif

    for (int t = 0; t < 24; t++) begin
      int r, n;
      logic [6:0] a;
      logic rw;
      hp = $urandom_range(8, 12);
      r = $urandom_range(0, 7);
      if (r == 0) a = 7'($urandom);
      else if (r == 1) a = 7'd0;
      else a = SADDR;
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      pay.delete();
      for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
      bus_start();
      xfer(a, rw);
      bus_stop();
      chk("rnd_busy_idle", busy, 0);
    end

    clks(10);
    chk("rx_left", exp_rx.size(), 0);
    chk("txack_total", n_txack, exp_txack);
    chk("rx_tx_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
